fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of the synchronous FIFO among NUM_REQ requesters.
//  Drives FIFO wr_en/data_in from registered outputs and returns a one-cycle grant per accepted word.
//  Throttles on full/almostfull so the FIFO never overflows, and flags any overflow it does observe.
//  Sits between requester agents and the FIFO write side; the FIFO read side is untouched.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  FIFO_WIDTH  16  data word width, equal to the FIFO data_in width
//  PTR_W       $clog2(NUM_REQ)  round-robin pointer width (derived, not overridden)
// PORTS
//  clk             in   1                  clock, rising edge
//  rst_n           in   1                  asynchronous active-low reset
//  req             in   NUM_REQ            per-requester write request; held until granted
//  req_data        in   NUM_REQ*FIFO_WIDTH word of requester i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//  gnt             out  NUM_REQ            one-hot pulse: the word was issued to the FIFO this cycle
//  fifo_full       in   1                  FIFO full
//  fifo_almostfull in   1                  FIFO almostfull (one slot left)
//  fifo_wr_ack     in   1                  FIFO wr_ack
//  fifo_overflow   in   1                  FIFO overflow
//  fifo_wr_en      out  1                  FIFO wr_en
//  fifo_data_in    out  FIFO_WIDTH         FIFO data_in
//  err_overflow    out  1                  sticky: overflow seen while this block wrote
//  busy            out  1                  1 in ISSUE or BUBBLE
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, fifo_wr_en=0, fifo_data_in=0, err_overflow=0, busy=0, rr_ptr=0, state=IDLE.
//  A reset mid-issue drops fifo_wr_en at once. The word in flight counts as not written.
//  All outputs are registered. No combinational path runs from inputs to outputs.
//  Arbitration: search starts at rr_ptr and moves upward with wrap; the first set req wins (idx).
//  On a grant, at the edge: gnt<=onehot(idx), fifo_wr_en<=1, fifo_data_in<=req_data[idx], rr_ptr<=idx+1 mod NUM_REQ.
//  Handshake: a requester that sees gnt[i]=1 must, in that cycle, either drop req[i] or present its next word.
//   A req that stays high is a new back-to-back request.
//  FSM (evaluated at each edge, using the current inputs):
//   IDLE:   if |req && !fifo_full, grant and go to ISSUE. Else stay; wr_en=0, gnt=0.
//   ISSUE:  wr_en=1 this cycle. Next edge:
//           if fifo_almostfull, go to BUBBLE, no grant (full lags by one cycle);
//           else if |req && !fifo_full, grant again and stay in ISSUE;
//           else go to IDLE.
//   BUBBLE: wr_en=0, gnt=0 for exactly one cycle, so the FIFO flags reflect the last write. Next edge behaves as IDLE.
//  Maximum throughput is one word per clock. Each requester waits at most NUM_REQ-1 grants (no starvation).
//  fifo_full=1 blocks any grant, whatever req is.
//  fifo_overflow=1 in a cycle after one with fifo_wr_en=1 sets err_overflow=1, held until reset.
//  fifo_wr_ack is used only for the optional check below.
//  fifo_data_in holds its last value when fifo_wr_en=0.
// CONFIGURATION
//  FIFO_ARB_ACK_CHECK_EN defined:
//   - The block tracks expected acks: a write issued without overflow must see fifo_wr_ack=1 one cycle later.
//   - A missing ack sets err_overflow as well. An unexpected ack also sets it.
//  FIFO_ARB_ACK_CHECK_EN undefined:
//   - fifo_wr_ack is ignored. err_overflow is driven only by fifo_overflow.
// TESTING
//  1. rst_n=0 mid-ISSUE -> all outputs 0 asynchronously; after release the first grant goes to req[0].
//  2. req=4'b1111 held, FIFO empty:
//     -> gnt order 0001,0010,0100,1000,0001
//     -> fifo_wr_en=1 continuously
//     -> fifo_data_in follows the granted word.
//  3. req=4'b0100 only, FIFO depth 8 -> 7 back-to-back writes, then BUBBLE on almostfull, 1 more write, then hold.
//     full=1 -> gnt=0; err_overflow stays 0.
//  4. fifo_full=1 with req=4'b1010 -> no gnt, fifo_wr_en=0. Full drops -> gnt=0010 on the next edge.
//  5. Force fifo_overflow=1 one cycle after a write -> err_overflow=1, held until rst_n=0.
//  6. With FIFO_ARB_ACK_CHECK_EN: suppress wr_ack after one write -> err_overflow=1. Without the macro -> stays 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Signal bundle between fifo_wr_arbiter, its requesters and the FIFO write side.
// master: the arbiter's view; slave: the environment (requesters + FIFO).
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          err_overflow;
    logic                          busy;

    modport master (
        input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_wr_en, fifo_data_in, err_overflow, busy
    );

    modport slave (
        output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        input  gnt, fifo_wr_en, fifo_data_in, err_overflow, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters; all outputs registered.
// Optional macro FIFO_ARB_ACK_CHECK_EN: missing or unexpected fifo_wr_ack also sets err_overflow.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W-1:0]      cand;
    logic [PTR_W-1:0]      ptr_next;
    logic                  found;
    logic                  do_grant;
    logic                  ack_err;
    logic [NUM_REQ-1:0]    gnt_q;
    logic                  wr_en_q;
    logic                  wr_en_d;
    logic                  err_q;
    logic                  busy_q;
    logic [FIFO_WIDTH-1:0] data_q;

    // Search upward from rr_ptr with wrap; first set request wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);

    // almostfull wins over a new grant in ISSUE: full lags the last write by a cycle.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        case (state)
            ISSUE: begin
                if (bus.fifo_almostfull) begin
                    state_next = BUBBLE;
                end else if (found && !bus.fifo_full) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (found && !bus.fifo_full) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

`ifdef FIFO_ARB_ACK_CHECK_EN
    assign ack_err = (wr_en_d && !bus.fifo_overflow && !bus.fifo_wr_ack) ||
                     (!wr_en_d && bus.fifo_wr_ack);
`else
    logic unused_wr_ack;
    assign unused_wr_ack = bus.fifo_wr_ack;
    assign ack_err       = 1'b0;
`endif

    // wr_en_d marks the cycle in which the FIFO reports on the previous write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_q   <= '0;
            wr_en_q <= 1'b0;
            wr_en_d <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            busy_q  <= (state_next != IDLE);
            wr_en_q <= do_grant;
            wr_en_d <= wr_en_q;
            gnt_q   <= do_grant ? (NUM_REQ'(1) << win_idx) : '0;
            if (do_grant) begin
                data_q <= bus.req_data[int'(win_idx)*FIFO_WIDTH +: FIFO_WIDTH];
                rr_ptr <= ptr_next;
            end
            if ((bus.fifo_overflow && wr_en_d) || ack_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.err_overflow = err_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, scoreboard queue and a small FIFO flag model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int DEPTH      = 8;
`ifdef FIFO_ARB_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    typedef struct {
        logic [3:0]  gnt;
        logic        wr_en;
        logic        busy;
        logic [15:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       af;
        logic [3:0] exp_gnt;
        logic       exp_wr_en;
        logic       exp_busy;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    string  phase    = "init";
    exp_t   sb[$];
    logic [7:0] tag  = 8'h00;
    logic   use_model    = 1'b0;
    logic   full_drv     = 1'b0;
    logic   af_drv       = 1'b0;
    logic   force_ovf    = 1'b0;
    logic   suppress_ack = 1'b0;

    // Word of requester i is {tag, i}, so the granted index is visible in the data.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = {tag, 8'(i)};
        end
    end

    // FIFO model: flags include the word being written this cycle.
    int   count;
    int   m_level;
    logic m_ack;
    logic m_ovf;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 0;
            m_ack <= 1'b0;
            m_ovf <= 1'b0;
        end else begin
            m_ack <= bus.fifo_wr_en && !(use_model && count >= DEPTH);
            m_ovf <= use_model && bus.fifo_wr_en && count >= DEPTH;
            if (bus.fifo_wr_en && count < DEPTH) count <= count + 1;
        end
    end
    assign m_level             = count + (bus.fifo_wr_en ? 1 : 0);
    assign bus.fifo_full       = use_model ? (m_level >= DEPTH) : full_drv;
    assign bus.fifo_almostfull = use_model ? (m_level == DEPTH - 1) : af_drv;
    assign bus.fifo_wr_ack     = m_ack && !suppress_ack;
    assign bus.fifo_overflow   = m_ovf || force_ovf;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s/%s actual=%0h required=%0h", phase, name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s/scoreboard actual=empty required=entry", phase);
        end else begin
            e = sb.pop_front();
            checkValue("gnt", 32'(bus.gnt), 32'(e.gnt));
            checkValue("wr_en", 32'(bus.fifo_wr_en), 32'(e.wr_en));
            checkValue("busy", 32'(bus.busy), 32'(e.busy));
            checkValue("data", 32'(bus.fifo_data_in), 32'(e.data));
            checkValue("err", 32'(bus.err_overflow), 32'(e.err));
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic f, input logic a, input exp_t e);
        bus.req  = r;
        full_drv = f;
        af_drv   = a;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkAllZero();
        checkValue("rst_gnt", 32'(bus.gnt), 32'h0);
        checkValue("rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        checkValue("rst_data", 32'(bus.fifo_data_in), 32'h0);
        checkValue("rst_err", 32'(bus.err_overflow), 32'h0);
        checkValue("rst_busy", 32'(bus.busy), 32'h0);
    endtask

    task automatic doReset();
        bus.req = '0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic w, input logic b,
                                input logic [15:0] d, input logic er);
        exp_t e;
        e.gnt = g; e.wr_en = w; e.busy = b; e.data = d; e.err = er;
        return e;
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        tbl [16];
        logic [15:0] exp_data;
        logic        w_seq [12];
        logic        b_seq [12];

        tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1};
        tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1};
        tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1};
        tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1};
        tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1};
        tbl[9]  = '{4'b1010, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1};
        tbl[10] = '{4'b1010, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[11] = '{4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1};
        tbl[12] = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1};
        tbl[14] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

        bus.req = '0;
        #2 rst_n = 1'b0;
        #10;
        phase = "reset";
        checkAllZero();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin order, full blocking, BUBBLE on almostfull.
        phase    = "table";
        exp_data = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            tag = 8'(k);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (tbl[k].exp_gnt[j]) exp_data = {8'(k), 8'(j)};
            end
            applyStimulus(tbl[k].req, tbl[k].full, tbl[k].af,
                          mk(tbl[k].exp_gnt, tbl[k].exp_wr_en, tbl[k].exp_busy, exp_data, 1'b0));
        end

        // Reset in the middle of ISSUE, then the pointer restarts at requester 0.
        phase = "mid_reset";
        tag   = 8'h20;
        applyStimulus(4'b0100, 1'b0, 1'b0, mk(4'b0100, 1'b1, 1'b1, 16'h2002, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        checkAllZero();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tag = 8'h21;
        applyStimulus(4'b1111, 1'b0, 1'b0, mk(4'b0001, 1'b1, 1'b1, 16'h2100, 1'b0));

        // Single requester filling an 8-deep FIFO.
        phase = "fill";
        doReset();
        use_model = 1'b1;
        tag       = 8'hC3;
        w_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        b_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0,
                          mk(w_seq[i] ? 4'b0100 : 4'b0000, w_seq[i], b_seq[i], 16'hC302, 1'b0));
        end
        use_model = 1'b0;

        // Overflow: ignored when no write preceded it, sticky after a write.
        phase = "overflow";
        doReset();
        tag       = 8'h55;
        force_ovf = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0));
        force_ovf = 1'b0;
        applyStimulus(4'b0001, 1'b0, 1'b0, mk(4'b0001, 1'b1, 1'b1, 16'h5500, 1'b0));
        applyStimulus(4'b0000, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 16'h5500, 1'b0));
        force_ovf = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 16'h5500, 1'b1));
        force_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 16'h5500, 1'b1));
        end
        rst_n = 1'b0;
        #1;
        checkValue("err_cleared", 32'(bus.err_overflow), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Missing write acknowledge.
        phase = "ack";
        doReset();
        tag = 8'h66;
        applyStimulus(4'b0001, 1'b0, 1'b0, mk(4'b0001, 1'b1, 1'b1, 16'h6600, 1'b0));
        applyStimulus(4'b0000, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 16'h6600, 1'b0));
        suppress_ack = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 16'h6600, ACK_CHK));
        suppress_ack = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, mk(4'b0000, 1'b0, 1'b0, 16'h6600, ACK_CHK));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
